pio_ep_reg_bank: RTL and testbench

PIO_EP_REG_BANK -- requirements
Module: pio_ep_reg_bank

---
 rtl/pio_ep_reg_pkg.sv | 52 +++++
 rtl/pio_chan_regs.sv | 140 ++++++++++++++
 rtl/pio_ep_reg_bank.sv | 162 ++++++++++++++++
 tb/tb_pio_ep_reg_bank.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pio_ep_reg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pio_ep_reg_pkg
//  Description : Shared constants for the PIO endpoint register bank:
//                region code, register offsets, per-channel reset values,
//                commit FSM state encoding and a byte-lane merge helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package pio_ep_reg_pkg;

    // addr[13:12] value selecting the register bank; all other regions read 0
    localparam logic [1:0] c_region_bank = 2'b01;

    // Register offsets within a channel (addr[3:0])
    localparam logic [3:0] c_off_if_v4      = 4'h0;
    localparam logic [3:0] c_off_if_mac_hi  = 4'h2;
    localparam logic [3:0] c_off_if_mac_lo  = 4'h3;
    localparam logic [3:0] c_off_dst_v4     = 4'h4;
    localparam logic [3:0] c_off_dst_mac_hi = 4'h6;
    localparam logic [3:0] c_off_dst_mac_lo = 4'h7;
    localparam logic [3:0] c_off_ctrl       = 4'h8;
    localparam logic [3:0] c_off_tx_cnt     = 4'hA;
    localparam logic [3:0] c_off_rx_cnt     = 4'hB;
    localparam logic [3:0] c_off_status     = 4'hF;

    // Reset values; the interface address/MAC bases get the channel index added
    localparam logic [31:0] c_rst_if_v4_base  = 32'hd000_0000;
    localparam logic [47:0] c_rst_if_mac_base = 48'h0037_7600_0001;
    localparam logic [31:0] c_rst_dst_v4      = 32'h0a00_15ff;
    localparam logic [47:0] c_rst_dst_mac     = 48'hffff_ffff_ffff;

    // Commit FSM encoding
    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_copy = 1'b1;

    // Byte-lane merge: lane i (be[i]) covers bits [31-8i -: 8], so be[0]
    // is the most significant byte.
    function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  be);
        logic [31:0] merged;
        merged = old_val;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                merged[31-8*i -: 8] = new_val[31-8*i -: 8];
            end
        end
        return merged;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pio_chan_regs.sv
`default_nettype none
// ============================================================================
//  Module      : pio_chan_regs
//  Description : One channel of the PIO endpoint register bank. Holds the
//                shadow (software-visible) and active (hardware-facing)
//                address sets, the enable bit and the TX/RX packet counters.
//  Ports       : clk, rst           - clock, synchronous active-high reset
//                i_wr_*             - qualified write for this channel
//                i_copy             - load active set from shadow
//                i_rd_off/o_rd_data - combinational register read by offset
//                i_tx/rx_pkt        - counter increment pulses
//                i_tx/rx_clr        - read-to-clear strobes
//                o_if_*/o_dst_*/o_en- active set
//  Revision    : 1.0 - initial release
// ============================================================================
module pio_chan_regs
    import pio_ep_reg_pkg::*;
#(
    parameter int CNT_W  = 32,
    parameter int CH_IDX = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_wr_en,
    input  logic [3:0]  i_wr_off,
    input  logic [3:0]  i_wr_be,
    input  logic [31:0] i_wr_data,
    input  logic        i_copy,
    input  logic [3:0]  i_rd_off,
    output logic [31:0] o_rd_data,
    input  logic        i_tx_pkt,
    input  logic        i_rx_pkt,
    input  logic        i_tx_clr,
    input  logic        i_rx_clr,
    output logic [31:0] o_if_v4,
    output logic [47:0] o_if_mac,
    output logic [31:0] o_dst_v4,
    output logic [47:0] o_dst_mac,
    output logic        o_en
);

    localparam logic [31:0] c_rst_if_v4  = c_rst_if_v4_base + 32'(CH_IDX);
    localparam logic [47:0] c_rst_if_mac = c_rst_if_mac_base + 48'(CH_IDX);

    logic [31:0]      r_sh_if_v4, r_sh_dst_v4, r_act_if_v4, r_act_dst_v4;
    logic [47:0]      r_sh_if_mac, r_sh_dst_mac, r_act_if_mac, r_act_dst_mac;
    logic             r_sh_en, r_act_en;
    logic [CNT_W-1:0] r_tx_cnt, r_rx_cnt;

    // Shadow registers, byte-lane writes
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh_if_v4   <= c_rst_if_v4;
            r_sh_if_mac  <= c_rst_if_mac;
            r_sh_dst_v4  <= c_rst_dst_v4;
            r_sh_dst_mac <= c_rst_dst_mac;
            r_sh_en      <= 1'b0;
        end else if (i_wr_en) begin
            case (i_wr_off)
                c_off_if_v4:      r_sh_if_v4 <= be_merge(r_sh_if_v4, i_wr_data, i_wr_be);
                c_off_if_mac_hi:  r_sh_if_mac[47:16] <= be_merge(r_sh_if_mac[47:16], i_wr_data, i_wr_be);
                c_off_if_mac_lo: begin
                    // Low MAC half lives in the top 16 bits: lanes 0-1 only
                    if (i_wr_be[0]) r_sh_if_mac[15:8] <= i_wr_data[31:24];
                    if (i_wr_be[1]) r_sh_if_mac[7:0]  <= i_wr_data[23:16];
                end
                c_off_dst_v4:     r_sh_dst_v4 <= be_merge(r_sh_dst_v4, i_wr_data, i_wr_be);
                c_off_dst_mac_hi: r_sh_dst_mac[47:16] <= be_merge(r_sh_dst_mac[47:16], i_wr_data, i_wr_be);
                c_off_dst_mac_lo: begin
                    if (i_wr_be[0]) r_sh_dst_mac[15:8] <= i_wr_data[31:24];
                    if (i_wr_be[1]) r_sh_dst_mac[7:0]  <= i_wr_data[23:16];
                end
                c_off_ctrl: begin
                    // Enable is bit 0, which sits in lane 3
                    if (i_wr_be[3]) r_sh_en <= i_wr_data[0];
                end
                default: ;
            endcase
        end
    end

    // Active set, loaded as a whole from shadow on commit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_act_if_v4   <= c_rst_if_v4;
            r_act_if_mac  <= c_rst_if_mac;
            r_act_dst_v4  <= c_rst_dst_v4;
            r_act_dst_mac <= c_rst_dst_mac;
            r_act_en      <= 1'b0;
        end else if (i_copy) begin
            r_act_if_v4   <= r_sh_if_v4;
            r_act_if_mac  <= r_sh_if_mac;
            r_act_dst_v4  <= r_sh_dst_v4;
            r_act_dst_mac <= r_sh_dst_mac;
            r_act_en      <= r_sh_en;
        end
    end

    // Saturating counters; a clear coincident with a pulse leaves 1
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_cnt <= '0;
            r_rx_cnt <= '0;
        end else begin
            if (i_tx_clr)
                r_tx_cnt <= {{(CNT_W-1){1'b0}}, i_tx_pkt};
            else if (i_tx_pkt && (r_tx_cnt != {CNT_W{1'b1}}))
                r_tx_cnt <= r_tx_cnt + CNT_W'(1);

            if (i_rx_clr)
                r_rx_cnt <= {{(CNT_W-1){1'b0}}, i_rx_pkt};
            else if (i_rx_pkt && (r_rx_cnt != {CNT_W{1'b1}}))
                r_rx_cnt <= r_rx_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        o_rd_data = 32'h0;
        case (i_rd_off)
            c_off_if_v4:      o_rd_data = r_sh_if_v4;
            c_off_if_mac_hi:  o_rd_data = r_sh_if_mac[47:16];
            c_off_if_mac_lo:  o_rd_data = {r_sh_if_mac[15:0], 16'h0};
            c_off_dst_v4:     o_rd_data = r_sh_dst_v4;
            c_off_dst_mac_hi: o_rd_data = r_sh_dst_mac[47:16];
            c_off_dst_mac_lo: o_rd_data = {r_sh_dst_mac[15:0], 16'h0};
            c_off_ctrl:       o_rd_data = {31'h0, r_sh_en};
            c_off_tx_cnt:     o_rd_data = 32'(r_tx_cnt);
            c_off_rx_cnt:     o_rd_data = 32'(r_rx_cnt);
            default:          o_rd_data = 32'h0;
        endcase
    end

    assign o_if_v4   = r_act_if_v4;
    assign o_if_mac  = r_act_if_mac;
    assign o_dst_v4  = r_act_dst_v4;
    assign o_dst_mac = r_act_dst_mac;
    assign o_en      = r_act_en;

endmodule
`default_nettype wire

// File: rtl/pio_ep_reg_bank.sv
`default_nettype none
// ============================================================================
//  Module      : pio_ep_reg_bank
//  Description : Multi-channel PIO endpoint register bank. Decodes the
//                register region and channel, routes writes to per-channel
//                shadow registers, runs the shadow->active commit FSM and
//                provides a registered read path with read-to-clear counters.
//  Ports       : clk, sys_rst              - clock, sync active-high reset
//                rd_addr/rd_en/rd_data     - read port (1-cycle latency)
//                wr_addr/wr_be/wr_data/wr_en, wr_busy - write port
//                if_*/dest_*/chan_en       - active sets, packed per channel
//                commit                    - per-channel commit pulse
//                tx_pkt/rx_pkt             - counter increment pulses
//                debug                     - status byte
//  Revision    : 1.0 - initial release
// ============================================================================
module pio_ep_reg_bank
    import pio_ep_reg_pkg::*;
#(
    parameter int NCH   = 2,
    parameter int CNT_W = 32,
    parameter int TCQ   = 1
) (
    input  logic              clk,
    input  logic              sys_rst,
    input  logic [13:0]       rd_addr,
    input  logic              rd_en,
    output logic [31:0]       rd_data,
    input  logic [13:0]       wr_addr,
    input  logic [7:0]        wr_be,
    input  logic [31:0]       wr_data,
    input  logic              wr_en,
    output logic              wr_busy,
    output logic [NCH*32-1:0] if_v4addr,
    output logic [NCH*32-1:0] dest_v4addr,
    output logic [NCH*48-1:0] if_macaddr,
    output logic [NCH*48-1:0] dest_macaddr,
    output logic [NCH-1:0]    chan_en,
    output logic [NCH-1:0]    commit,
    input  logic [NCH-1:0]    tx_pkt,
    input  logic [NCH-1:0]    rx_pkt,
    input  logic [7:0]        debug
);

    // TCQ is kept for compatibility with delay-annotated simulation flows;
    // this RTL models no clock-to-out delay.
    localparam int c_unused_tcq = TCQ;

    // Write decode
    logic [2:0]  w_wr_ch;
    logic [3:0]  w_wr_off;
    logic        w_wr_hit, w_wr_acc, w_commit_req;

    assign w_wr_ch      = wr_addr[6:4];
    assign w_wr_off     = wr_addr[3:0];
    assign w_wr_hit     = (wr_addr[13:12] == c_region_bank) && ({29'd0, w_wr_ch} < 32'(NCH));
    assign w_wr_acc     = wr_en && !wr_busy && w_wr_hit;
    // Shadow update and commit request happen on the same edge, so the copy
    // in the following cycle sees the freshly written CTRL byte.
    assign w_commit_req = w_wr_acc && (w_wr_off == c_off_ctrl) && wr_data[31] && wr_be[0];

    // Read decode
    logic [2:0]  w_rd_ch;
    logic [3:0]  w_rd_off;
    logic        w_rd_hit;
    logic [31:0] w_rd_next;
    logic [31:0] w_ch_rd [NCH];

    assign w_rd_ch  = rd_addr[6:4];
    assign w_rd_off = rd_addr[3:0];
    assign w_rd_hit = (rd_addr[13:12] == c_region_bank) && ({29'd0, w_rd_ch} < 32'(NCH));

    // Commit FSM
    logic [0:0] r_state, w_state_nxt;
    logic [2:0] r_commit_ch, w_commit_ch_nxt;

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            r_state     <= c_st_idle;
            r_commit_ch <= 3'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_commit_ch <= w_commit_ch_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_commit_ch_nxt = r_commit_ch;
        case (r_state)
            c_st_idle: begin
                if (w_commit_req) begin
                    w_state_nxt     = c_st_copy;
                    w_commit_ch_nxt = w_wr_ch;
                end
            end
            c_st_copy: w_state_nxt = c_st_idle;
            default:   w_state_nxt = c_st_idle;
        endcase
    end

    assign wr_busy = (r_state == c_st_copy);

    // Channel instances
    for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
        logic w_sel_wr, w_sel_rd;

        assign w_sel_wr    = w_wr_acc && (w_wr_ch == 3'(gi));
        assign w_sel_rd    = rd_en && w_rd_hit && (w_rd_ch == 3'(gi));
        assign commit[gi]  = wr_busy && (r_commit_ch == 3'(gi));

        pio_chan_regs #(
            .CNT_W  (CNT_W),
            .CH_IDX (gi)
        ) u_chan (
            .clk       (clk),
            .rst       (sys_rst),
            .i_wr_en   (w_sel_wr),
            .i_wr_off  (w_wr_off),
            .i_wr_be   (wr_be[3:0]),
            .i_wr_data (wr_data),
            .i_copy    (commit[gi]),
            .i_rd_off  (w_rd_off),
            .o_rd_data (w_ch_rd[gi]),
            .i_tx_pkt  (tx_pkt[gi]),
            .i_rx_pkt  (rx_pkt[gi]),
            .i_tx_clr  (w_sel_rd && (w_rd_off == c_off_tx_cnt)),
            .i_rx_clr  (w_sel_rd && (w_rd_off == c_off_rx_cnt)),
            .o_if_v4   (if_v4addr[gi*32 +: 32]),
            .o_if_mac  (if_macaddr[gi*48 +: 48]),
            .o_dst_v4  (dest_v4addr[gi*32 +: 32]),
            .o_dst_mac (dest_macaddr[gi*48 +: 48]),
            .o_en      (chan_en[gi])
        );
    end

    // Read mux, registered for one-cycle latency
    always_comb begin
        w_rd_next = 32'h0;
        if (w_rd_hit) begin
            if (w_rd_off == c_off_status) begin
                w_rd_next = {24'h0, debug};
            end else begin
                for (int i = 0; i < NCH; i++) begin
                    if (w_rd_ch == 3'(i)) w_rd_next = w_ch_rd[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (sys_rst) rd_data <= 32'h0;
        else         rd_data <= w_rd_next;
    end

    // Address bits outside region/channel/offset and the upper byte enables
    // carry no meaning here.
    logic w_unused_ok;
    assign w_unused_ok = &{1'b0, wr_be[7:4], wr_addr[11:7], rd_addr[11:7]};

endmodule
`default_nettype wire

// File: tb/tb_pio_ep_reg_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pio_ep_reg_bank
//  Description : Self-checking bench for pio_ep_reg_bank. Reads push their
//                expected data into a scoreboard queue; a monitor pops and
//                compares when read data becomes valid.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pio_ep_reg_bank;

    logic        clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic [13:0] rd_addr = '0;
    logic        rd_en = 1'b0;
    logic [31:0] rd_data;
    logic [13:0] wr_addr = '0;
    logic [7:0]  wr_be = '0;
    logic [31:0] wr_data = '0;
    logic        wr_en = 1'b0;
    logic        wr_busy;
    logic [63:0] if_v4addr, dest_v4addr;
    logic [95:0] if_macaddr, dest_macaddr;
    logic [1:0]  chan_en, commit;
    logic [1:0]  tx_pkt = '0, rx_pkt = '0;
    logic [7:0]  debug = 8'hA5;

    // 16-bit counter instance for saturation
    logic [13:0] rd_addr16 = '0;
    logic        rd_en16 = 1'b0;
    logic [31:0] rd_data16;
    logic        wr_busy16;
    logic [63:0] if_v4_16, dst_v4_16;
    logic [95:0] if_mac_16, dst_mac_16;
    logic [1:0]  chan_en16, commit16;
    logic [1:0]  tx16 = '0;
    logic [1:0]  rx16 = '0;
    logic [13:0] wr_addr16 = '0;
    logic [7:0]  wr_be16 = '0;
    logic [31:0] wr_data16 = '0;
    logic        wr_en16 = 1'b0;

    always #5 clk = ~clk;

    pio_ep_reg_bank #(.NCH(2), .CNT_W(32), .TCQ(1)) dut (
        .clk(clk), .sys_rst(sys_rst),
        .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data),
        .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data), .wr_en(wr_en),
        .wr_busy(wr_busy),
        .if_v4addr(if_v4addr), .dest_v4addr(dest_v4addr),
        .if_macaddr(if_macaddr), .dest_macaddr(dest_macaddr),
        .chan_en(chan_en), .commit(commit),
        .tx_pkt(tx_pkt), .rx_pkt(rx_pkt), .debug(debug)
    );

    pio_ep_reg_bank #(.NCH(2), .CNT_W(16), .TCQ(1)) dut16 (
        .clk(clk), .sys_rst(sys_rst),
        .rd_addr(rd_addr16), .rd_en(rd_en16), .rd_data(rd_data16),
        .wr_addr(wr_addr16), .wr_be(wr_be16), .wr_data(wr_data16), .wr_en(wr_en16),
        .wr_busy(wr_busy16),
        .if_v4addr(if_v4_16), .dest_v4addr(dst_v4_16),
        .if_macaddr(if_mac_16), .dest_macaddr(dst_mac_16),
        .chan_en(chan_en16), .commit(commit16),
        .tx_pkt(tx16), .rx_pkt(rx16), .debug(debug)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard
    logic [31:0] exp_q[$];
    string       name_q[$];
    logic        rd_req = 1'b0;
    logic        rd_vld_d = 1'b0;
    logic [31:0] mon_exp;
    string       mon_name;

    always @(posedge clk) rd_vld_d <= rd_req;

    always @(negedge clk) begin
        if (rd_vld_d) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL rd_unexpected: got 0x%0h, expected no read", rd_data);
            end else begin
                mon_exp  = exp_q.pop_front();
                mon_name = name_q.pop_front();
                check(mon_name, {32'h0, rd_data}, {32'h0, mon_exp});
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input string name, input logic [13:0] a, input logic en, input logic [31:0] exp);
        rd_addr = a;
        rd_en   = en;
        rd_req  = 1'b1;
        exp_q.push_back(exp);
        name_q.push_back(name);
        tick;
        rd_req = 1'b0;
        rd_en  = 1'b0;
    endtask

    task automatic wr(input logic [13:0] a, input logic [7:0] be, input logic [31:0] d);
        wr_addr = a;
        wr_be   = be;
        wr_data = d;
        wr_en   = 1'b1;
        tick;
        wr_en = 1'b0;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick;
        sys_rst = 1'b0;
        @(negedge clk);
        check("rst_rd_data",     {32'h0, rd_data}, 64'h0);
        check("rst_commit",      {62'h0, commit}, 64'h0);
        check("rst_wr_busy",     {63'h0, wr_busy}, 64'h0);
        check("rst_chan_en",     {62'h0, chan_en}, 64'h0);
        check("rst_if_v4_ch1",   {32'h0, if_v4addr[63:32]}, 64'hd000_0001);
        check("rst_if_mac_ch0",  {16'h0, if_macaddr[47:0]}, 64'h0037_7600_0001);
        check("rst_dst_v4_ch0",  {32'h0, dest_v4addr[31:0]}, 64'h0a00_15ff);
        check("rst_dst_mac_ch1", {16'h0, dest_macaddr[95:48]}, 64'hffff_ffff_ffff);

        // Reset contents through the read port
        rd("rd_if_v4_ch1",     14'h1010, 1'b1, 32'hd000_0001);
        rd("rd_if_mac_hi_ch1", 14'h1012, 1'b0, 32'h0037_7600);
        rd("rd_if_mac_lo_ch1", 14'h1013, 1'b0, 32'h0002_0000);
        rd("rd_dst_v4_ch1",    14'h1014, 1'b0, 32'h0a00_15ff);
        rd("rd_dst_mac_hi",    14'h1016, 1'b0, 32'hffff_ffff);
        rd("rd_dst_mac_lo",    14'h1017, 1'b0, 32'hffff_0000);
        rd("rd_ctrl_ch1",      14'h1018, 1'b0, 32'h0);
        rd("rd_gap_off1",      14'h1011, 1'b0, 32'h0);
        rd("rd_status",        14'h100F, 1'b0, 32'h0000_00A5);
        rd("rd_bad_chan",      14'h1020, 1'b0, 32'h0);
        rd("rd_region0",       14'h0010, 1'b0, 32'h0);
        rd("rd_region3",       14'h3000, 1'b0, 32'h0);

        // Partial byte-lane write: lanes 0 and 2 only
        wr(14'h1000, 8'h05, 32'h0a00_0001);
        rd("wr_lanes_0_2", 14'h1000, 1'b0, 32'h0a00_0000);
        @(negedge clk);
        check("active_unchanged", {32'h0, if_v4addr[31:0]}, 64'hd000_0000);

        // Writes to other regions / absent channel are ignored
        wr(14'h0000, 8'h0F, 32'h1111_1111);
        wr(14'h2000, 8'h0F, 32'h2222_2222);
        wr(14'h1020, 8'h0F, 32'h3333_3333);
        rd("wr_ignored", 14'h1000, 1'b0, 32'h0a00_0000);

        // MAC_LO only honours lanes 0-1
        wr(14'h1013, 8'h0E, 32'hABCD_1234);
        rd("wr_mac_lo", 14'h1013, 1'b0, 32'h00CD_0000);

        // Commit channel 0, with a write arriving during the copy
        wr_addr = 14'h1008; wr_be = 8'h0F; wr_data = 32'h8000_0001; wr_en = 1'b1;
        tick;
        wr_addr = 14'h1000; wr_be = 8'h0F; wr_data = 32'h1234_5678; wr_en = 1'b1;
        @(negedge clk);
        check("commit_pulse",    {62'h0, commit}, 64'h1);
        check("wr_busy_copy",    {63'h0, wr_busy}, 64'h1);
        check("active_pre_copy", {32'h0, if_v4addr[31:0]}, 64'hd000_0000);
        tick;
        wr_en = 1'b0;
        @(negedge clk);
        check("commit_done",     {62'h0, commit}, 64'h0);
        check("wr_busy_done",    {63'h0, wr_busy}, 64'h0);
        check("active_if_v4",    {32'h0, if_v4addr[31:0]}, 64'h0a00_0000);
        check("chan_en_after",   {62'h0, chan_en}, 64'h1);
        check("active_if_mac0",  {16'h0, if_macaddr[47:0]}, 64'h0037_7600_0001);
        check("ch1_not_commit",  {16'h0, if_macaddr[95:48]}, 64'h0037_7600_0002);
        rd("busy_write_dropped", 14'h1000, 1'b0, 32'h0a00_0000);
        rd("rd_ctrl_ch0",        14'h1008, 1'b0, 32'h0000_0001);

        // CTRL write without the commit bit: shadow only
        wr(14'h1018, 8'h08, 32'h0000_0001);
        @(negedge clk);
        check("no_commit",      {62'h0, commit}, 64'h0);
        check("no_busy",        {63'h0, wr_busy}, 64'h0);
        rd("rd_ctrl_ch1_set", 14'h1018, 1'b0, 32'h0000_0001);
        @(negedge clk);
        check("chan_en_ch1_off", {62'h0, chan_en}, 64'h1);

        // Counters: increment, read-to-clear, coincident pulse, passive read
        tx_pkt = 2'b10;
        repeat (5) tick;
        tx_pkt = 2'b00;
        rd("tx_cnt_5",     14'h101A, 1'b1, 32'd5);
        rd("tx_cnt_clr",   14'h101A, 1'b1, 32'd0);
        tx_pkt = 2'b10;
        rd("tx_clr_coinc", 14'h101A, 1'b1, 32'd0);
        tx_pkt = 2'b00;
        rd("tx_after_coinc", 14'h101A, 1'b0, 32'd1);
        rd("tx_passive",     14'h101A, 1'b0, 32'd1);
        rx_pkt = 2'b01;
        repeat (3) tick;
        rx_pkt = 2'b00;
        rd("rx_cnt_3",   14'h100B, 1'b1, 32'd3);
        rd("tx_ch0_zero", 14'h100A, 1'b0, 32'd0);

        // 16-bit counter saturation
        tx16 = 2'b01;
        repeat (65540) tick;
        tx16 = 2'b00;
        rd_addr16 = 14'h100A;
        rd_en16   = 1'b1;
        tick;
        rd_en16 = 1'b0;
        @(negedge clk);
        check("cnt16_saturate", {32'h0, rd_data16}, 64'h0000_ffff);
        rd_addr16 = 14'h1020;
        tick;
        @(negedge clk);
        check("cnt16_bad_chan", {32'h0, rd_data16}, 64'h0);

        repeat (3) tick;
        check("scoreboard_drained", 64'(exp_q.size()), 64'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
